// File: rtl/vcmd_pkg.sv
// Shared opcodes, decoder states and sizing helpers for the video command decoder.
package vcmd_pkg;

  localparam logic [7:0] CMD_SETADDR_DEF = 8'h01;
  localparam logic [7:0] CMD_PIXEL_DEF   = 8'h41;
  localparam logic [7:0] CMD_BURST_DEF   = 8'h42;
  localparam logic [7:0] CMD_NOP_DEF     = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_PIX
  } state_e;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int bytes_for_bits(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/vcmd_byte_assembler.sv
// MSB-first byte shift register: collects NBYTES bytes and strobes done_o on
// the last one, presenting the completed word on word_o in that same cycle.
module vcmd_byte_assembler
  import vcmd_pkg::*;
#(
  parameter int NBYTES = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  shift_i,
  input  logic [7:0]            byte_i,
  output logic [8*NBYTES-1:0]   word_o,
  output logic                  done_o
);

  localparam int            CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [8*NBYTES-1:0] data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Word as it looks with the incoming byte appended; valid when done_o is set.
  always_comb begin
    word_o = (data_q << 8) | (8 * NBYTES)'(byte_i);
    done_o = shift_i && (cnt_q == LAST);
  end

  // Next-state for the partial word and byte count.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      if (done_o) begin
        data_d = '0;
        cnt_d  = '0;
      end else begin
        data_d = word_o;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // Partial word and byte count registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/vcmd_burst_decoder.sv
// Video command decoder: turns the SPI byte stream into addressed pixel
// writes with set-address, single-pixel and auto-incrementing burst commands.
module vcmd_burst_decoder
  import vcmd_pkg::*;
#(
  parameter int         AWIDTH      = 18,
  parameter int         CHANNELS    = 3,
  parameter logic [7:0] CMD_SETADDR = CMD_SETADDR_DEF,
  parameter logic [7:0] CMD_PIXEL   = CMD_PIXEL_DEF,
  parameter logic [7:0] CMD_BURST   = CMD_BURST_DEF,
  parameter logic [7:0] CMD_NOP     = CMD_NOP_DEF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  input  logic                  abort_i,
  input  logic                  data_mode_enable_i,
  output logic                  pixel_valid_o,
  input  logic                  pixel_ready_i,
  output logic [AWIDTH-1:0]     addr_o,
  output logic [8*CHANNELS-1:0] pixel_o,
  output logic                  busy_o,
  output logic                  cmd_error_o
);

  localparam int ABYTES = bytes_for_bits(AWIDTH);

  state_e                state_q, state_d;
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic [AWIDTH-1:0]     addr_out_q, addr_out_d;
  logic [8*CHANNELS-1:0] pixel_out_q, pixel_out_d;
  logic                  pix_valid_q, pix_valid_d;
  logic [7:0]            remaining_q, remaining_d;
  logic                  cmd_error_q, cmd_error_d;

  logic                  byte_accept;
  logic                  asm_clear;
  logic                  addr_shift, pix_shift;
  logic                  addr_done, pix_done;
  logic [8*ABYTES-1:0]   addr_word;
  logic [8*CHANNELS-1:0] pix_word;

  assign byte_ready_o  = !pix_valid_q && !abort_i;
  assign byte_accept   = byte_valid_i && byte_ready_o;
  assign pixel_valid_o = pix_valid_q;
  assign addr_o        = addr_out_q;
  assign pixel_o       = pixel_out_q;
  assign busy_o        = (state_q != ST_IDLE) || pix_valid_q;
  assign cmd_error_o   = cmd_error_q;

  vcmd_byte_assembler #(.NBYTES(ABYTES)) u_addr_asm (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (asm_clear),
    .shift_i (addr_shift),
    .byte_i  (byte_i),
    .word_o  (addr_word),
    .done_o  (addr_done)
  );

  vcmd_byte_assembler #(.NBYTES(CHANNELS)) u_pix_asm (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (asm_clear),
    .shift_i (pix_shift),
    .byte_i  (byte_i),
    .word_o  (pix_word),
    .done_o  (pix_done)
  );

  // Command FSM next-state, write handshake and byte routing to the assemblers.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    addr_out_d  = addr_out_q;
    pixel_out_d = pixel_out_q;
    pix_valid_d = pix_valid_q;
    remaining_d = remaining_q;
    cmd_error_d = cmd_error_q;
    asm_clear   = 1'b0;
    addr_shift  = 1'b0;
    pix_shift   = 1'b0;

    // A pending write always completes, even across abort or data-mode-off.
    if (pix_valid_q && pixel_ready_i) begin
      pix_valid_d = 1'b0;
      addr_d      = addr_q + 1'b1;
    end

    if (abort_i || !data_mode_enable_i) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      asm_clear   = 1'b1;
    end else if (byte_accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_i == CMD_SETADDR) begin
            state_d = ST_ADDR;
          end else if (byte_i == CMD_PIXEL) begin
            state_d     = ST_PIX;
            remaining_d = '0;
          end else if (byte_i == CMD_BURST) begin
            state_d = ST_COUNT;
          end else if (byte_i != CMD_NOP) begin
            cmd_error_d = 1'b1;
          end
        end
        ST_ADDR: begin
          addr_shift = 1'b1;
          if (addr_done) begin
            // Upper bits beyond AWIDTH are dropped by the width cast.
            addr_d  = AWIDTH'(addr_word);
            state_d = ST_IDLE;
          end
        end
        ST_COUNT: begin
          remaining_d = byte_i;
          state_d     = ST_PIX;
        end
        ST_PIX: begin
          pix_shift = 1'b1;
          if (pix_done) begin
            pix_valid_d = 1'b1;
            addr_out_d  = addr_q;
            pixel_out_d = pix_word;
            if (remaining_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              remaining_d = remaining_q - 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, address and output registers.
  always_ff @(posedge clk_i) begin
    // NOTE: every register here is reset, including the data-path outputs, so AddrOut/PixelOut read 0 after reset.
    if (reset_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      addr_out_q  <= '0;
      pixel_out_q <= '0;
      pix_valid_q <= 1'b0;
      remaining_q <= '0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      addr_out_q  <= addr_out_d;
      pixel_out_q <= pixel_out_d;
      pix_valid_q <= pix_valid_d;
      remaining_q <= remaining_d;
      cmd_error_q <= cmd_error_d;
    end
  end

endmodule
